// File: rtl/dual_channel_consumer_pkg.sv
// =============================================================================
// Module      : dual_channel_consumer_pkg
// Description : Shared widths, beat layout and channel encoding for the
//               dual-channel stream consumer. Provides fallback values for the
//               shared interface width defines when they are not already set.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef FIFO_ENTRY_WIDTH
`define FIFO_ENTRY_WIDTH (`ADDRESS_WIDTH + `ID_WIDTH)
`endif

package dual_channel_consumer_pkg;

   localparam int ADDR_W  = `ADDRESS_WIDTH;
   localparam int ID_W    = `ID_WIDTH;
   localparam int ENTRY_W = `FIFO_ENTRY_WIDTH;

   // Sequence checker start values and address stride
   localparam int SEQ_ID_RESET   = 1;
   localparam int SEQ_ADDR_RESET = 4;
   localparam int SEQ_ADDR_STEP  = 4;

   typedef enum logic {
      CH1 = 1'b0,
      CH2 = 1'b1
   } chan_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } beat_t;

endpackage

`default_nettype wire

// File: rtl/dual_channel_consumer_fifo.sv
// =============================================================================
// Module      : consumer_fifo
// Description : Per-channel first-word-fall-through FIFO. Head is the oldest
//               entry; a write and a read at the same edge are both honoured,
//               including when full. Writes into a full FIFO without a read
//               are dropped.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module consumer_fifo #(
   parameter int FIFO_DEPTH  = 4,
   parameter int PTR_WIDTH   = 2,
   parameter int ENTRY_WIDTH = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_i,
   input  logic                   rd_i,
   input  logic [ENTRY_WIDTH-1:0] wdata_i,
   output logic [ENTRY_WIDTH-1:0] head_o,
   output logic [PTR_WIDTH:0]     count_o
);

   localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);

   logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]   wptr_q, rptr_q;
   logic [PTR_WIDTH:0]     count_q;
   logic                   do_wr, do_rd;

   assign do_rd   = rd_i && (count_q != '0);
   assign do_wr   = wr_i && ((count_q != DEPTH_C) || do_rd);
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Storage array: data only, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wdata_i;
   end

   // Pointers wrap naturally at PTR_WIDTH bits; count tracks occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/dual_channel_consumer.sv
// =============================================================================
// Module      : dual_channel_consumer
// Description : Two-channel address/id stream receiver. Each channel buffers
//               into its own FIFO with early stall; heads are merged
//               round-robin onto one valid/ready output with a grant lock.
//               Optional per-channel sequence continuity checker, enabled by
//               defining CONSUMER_SEQ_CHECK_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module dual_channel_consumer
   import dual_channel_consumer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_WIDTH  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [`ADDRESS_WIDTH-1:0] in_address_1,
   input  logic [`ID_WIDTH-1:0]      in_id_1,
   input  logic                      in_valid_1,
   output logic                      out_stall_1,
   input  logic [`ADDRESS_WIDTH-1:0] in_address_2,
   input  logic [`ID_WIDTH-1:0]      in_id_2,
   input  logic                      in_valid_2,
   output logic                      out_stall_2,
   output logic [`ADDRESS_WIDTH-1:0] out_address,
   output logic [`ID_WIDTH-1:0]      out_id,
   output logic                      out_channel,
   output logic                      out_valid,
   input  logic                      in_ready,
   output logic                      err_overflow_1,
   output logic                      err_overflow_2,
   output logic                      err_seq_1,
   output logic                      err_seq_2
);

   localparam logic [PTR_WIDTH:0]   DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [PTR_WIDTH+1:0] DEPTH_X = (PTR_WIDTH+2)'(FIFO_DEPTH);

   beat_t [1:0]             in_beat, head;
   beat_t                   sel;
   logic  [1:0]             in_vld, acc, rd, ne, stall, ovf, seq_err;
   logic  [1:0][PTR_WIDTH:0] cnt;
   chan_e                   grant, rr_q, lock_ch_q;
   logic                    lock_q, valid, xfer;

   assign in_beat[0] = '{addr: in_address_1, id: in_id_1};
   assign in_beat[1] = '{addr: in_address_2, id: in_id_2};
   assign in_vld     = {in_valid_2, in_valid_1};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      consumer_fifo #(
         .FIFO_DEPTH  (FIFO_DEPTH),
         .PTR_WIDTH   (PTR_WIDTH),
         .ENTRY_WIDTH (ENTRY_W)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_i    (in_vld[c]),
         .rd_i    (rd[c]),
         .wdata_i (in_beat[c]),
         .head_o  (head[c]),
         .count_o (cnt[c])
      );

      assign ne[c]    = (cnt[c] != '0);
      // Counting the beat on the wire covers the one the registered source
      // launches after sampling stall low
      assign stall[c] = ((PTR_WIDTH+2)'(cnt[c]) + (PTR_WIDTH+2)'(in_vld[c])) >= DEPTH_X;
      assign acc[c]   = in_vld[c] && ((cnt[c] != DEPTH_C) || rd[c]);

      logic ovf_q;
      // A beat finding no room is lost; remember that until reset
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                     ovf_q <= 1'b0;
         else if (in_vld[c] && !acc[c]) ovf_q <= 1'b1;
      end
      assign ovf[c] = ovf_q;

`ifdef CONSUMER_SEQ_CHECK_EN
      logic [ID_W-1:0]   exp_id_q;
      logic [ADDR_W-1:0] exp_addr_q;
      logic              seq_err_q;
      // Compare each stored beat with the prediction, then resync to it
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            exp_id_q   <= ID_W'(SEQ_ID_RESET);
            exp_addr_q <= ADDR_W'(SEQ_ADDR_RESET);
            seq_err_q  <= 1'b0;
         end else if (acc[c]) begin
            if ((in_beat[c].id != exp_id_q) || (in_beat[c].addr != exp_addr_q))
               seq_err_q <= 1'b1;
            exp_id_q   <= in_beat[c].id + ID_W'(1);
            exp_addr_q <= in_beat[c].addr + ADDR_W'(SEQ_ADDR_STEP);
         end
      end
      assign seq_err[c] = seq_err_q;
`else
      assign seq_err[c] = 1'b0;
`endif
   end

   // Grant: held while locked, else the only non-empty FIFO, else RR choice
   always_comb begin
      grant = CH1;
      if (lock_q)                grant = lock_ch_q;
      else if (ne[0] && ne[1])   grant = rr_q;
      else if (ne[1])            grant = CH2;
   end

   assign valid = (grant == CH2) ? ne[1] : ne[0];
   assign xfer  = valid && in_ready;
   assign rd    = {xfer && (grant == CH2), xfer && (grant == CH1)};
   assign sel   = (grant == CH2) ? head[1] : head[0];

   // Lock the grant while the head is offered but not taken; rotate on transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q      <= CH1;
         lock_q    <= 1'b0;
         lock_ch_q <= CH1;
      end else begin
         lock_q    <= valid && !in_ready;
         lock_ch_q <= grant;
         if (xfer) rr_q <= (grant == CH1) ? CH2 : CH1;
      end
   end

   assign out_address    = sel.addr;
   assign out_id         = sel.id;
   assign out_channel    = (grant == CH2);
   assign out_valid      = valid;
   assign out_stall_1    = stall[0];
   assign out_stall_2    = stall[1];
   assign err_overflow_1 = ovf[0];
   assign err_overflow_2 = ovf[1];
   assign err_seq_1      = seq_err[0];
   assign err_seq_2      = seq_err[1];

endmodule

`default_nettype wire
